// File: rtl/am2912_bus_arbiter_pkg.sv
// Shared definitions for am2912 open-collector bus controllers: state encoding,
// transceiver enable polarity, counter widths and a modular index helper.
package am2912_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_OWN     = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        SETTLE  = ST_SETTLE,
        OWN     = ST_OWN,
        RECOVER = ST_RECOVER
    } arb_state_t;

    // am2912 E_ is active-low: a bank drives the bus only while its enable is 0.
    localparam logic AM2912_E_ON  = 1'b0;
    localparam logic AM2912_E_OFF = 1'b1;

    localparam int CNT_W  = 4;
    localparam int HOLD_W = 8;

    function automatic int rr_next(input int base, input int step, input int n);
        int v;
        v = base + step;
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/am2912_bus_arbiter_if.sv
// Request/grant/enable bundle between the arbiter and the requesters sharing
// one wired-AND am2912 bus segment.
interface am2912_bus_arbiter_if #(
    parameter int NREQ = 4
);
    import am2912_bus_arbiter_pkg::*;

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] e_;
    logic            strb;
    logic [IW-1:0]   owner;
    logic            busy;

    modport master (
        input  req,
        output gnt,
        output e_,
        output strb,
        output owner,
        output busy
    );

    modport slave (
        output req,
        input  gnt,
        input  e_,
        input  strb,
        input  owner,
        input  busy
    );

endinterface

// File: rtl/am2912_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching from last+1
// upward, wrapping modulo NREQ.
module am2912_rr_pick
    import am2912_bus_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   idx,
    output logic [NREQ-1:0] onehot
);

    logic [IW-1:0] cand;

    // Scan from farthest to nearest so the nearest set request is written last.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IW'(rr_next(int'(last), i, NREQ));
            if (req[cand]) begin
                valid        = 1'b1;
                idx          = cand;
                onehot       = '0;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/am2912_bus_arbiter.sv
// Round-robin sequencer for a shared am2912 wired-AND bus: grants one bank,
// waits for pull-up settle, strobes receivers, and enforces a recovery gap.
module am2912_bus_arbiter
    import am2912_bus_arbiter_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int SETTLE_CYC  = 1,
    parameter int RECOVER_CYC = 1,
    parameter int MAX_HOLD    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    am2912_bus_arbiter_if.master  bus
);

    localparam int IW = $clog2(NREQ);

    localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  RECOVER_LAST = CNT_W'(RECOVER_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT   = HOLD_W'(MAX_HOLD);

    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("am2912_bus_arbiter: NREQ must be in 2..16");
    end
    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("am2912_bus_arbiter: SETTLE_CYC must be in 1..15");
    end
    if (RECOVER_CYC < 1 || RECOVER_CYC > 15) begin : g_bad_recover
        $error("am2912_bus_arbiter: RECOVER_CYC must be in 1..15");
    end
    if (MAX_HOLD < 0 || MAX_HOLD > 255) begin : g_bad_hold
        $error("am2912_bus_arbiter: MAX_HOLD must be in 0..255");
    end

    arb_state_t        state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   e_q;
    logic              strb_q;
    logic              busy_q;
    logic [IW-1:0]     owner_q;
    logic [IW-1:0]     last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [HOLD_W-1:0] hold_q;

    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic [NREQ-1:0]   pick_onehot;
    logic              own_req;
    logic              hold_expired;

    am2912_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (bus.req),
        .last   (last_q),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign own_req      = bus.req[owner_q];
    assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            e_q     <= {NREQ{AM2912_E_OFF}};
            strb_q  <= 1'b0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= SETTLE;
                        gnt_q   <= pick_onehot;
                        e_q     <= ~pick_onehot;
                        busy_q  <= 1'b1;
                        owner_q <= pick_idx;
                        last_q  <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                SETTLE: begin
                    if (!own_req) begin
                        state_q <= RECOVER;
                        gnt_q   <= '0;
                        e_q     <= {NREQ{AM2912_E_OFF}};
                        owner_q <= '0;
                        cnt_q   <= '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_q <= OWN;
                        strb_q  <= 1'b1;
                        hold_q  <= HOLD_W'(1);
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // hold_q counts strobe cycles already shown, so expiry and a
                // dropped request on the same edge collapse into one release.
                OWN: begin
                    if (!own_req || hold_expired) begin
                        state_q <= RECOVER;
                        gnt_q   <= '0;
                        e_q     <= {NREQ{AM2912_E_OFF}};
                        strb_q  <= 1'b0;
                        owner_q <= '0;
                        cnt_q   <= '0;
                    end else if (hold_q != '1) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                RECOVER: begin
                    if (cnt_q == RECOVER_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.e_    = e_q;
    assign bus.strb  = strb_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;

endmodule

// File: tb/tb_am2912_bus_arbiter.sv
// Bench for am2912_bus_arbiter: picker vector table, directed multi-cycle
// sequences, and randomized traffic against a tenure-level reference model.
module tb_am2912_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    am2912_bus_arbiter_if #(.NREQ(4)) if0 ();
    am2912_bus_arbiter_if #(.NREQ(4)) if1 ();
    am2912_bus_arbiter_if #(.NREQ(4)) if2 ();
    am2912_bus_arbiter_if #(.NREQ(4)) if3 ();

    am2912_bus_arbiter #(.NREQ(4), .SETTLE_CYC(1), .RECOVER_CYC(1), .MAX_HOLD(16))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    am2912_bus_arbiter #(.NREQ(4), .SETTLE_CYC(1), .RECOVER_CYC(1), .MAX_HOLD(4))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    am2912_bus_arbiter #(.NREQ(4), .SETTLE_CYC(3), .RECOVER_CYC(1), .MAX_HOLD(16))
        u2 (.clk(clk), .rst(rst), .bus(if2));
    am2912_bus_arbiter #(.NREQ(4), .SETTLE_CYC(1), .RECOVER_CYC(1), .MAX_HOLD(0))
        u3 (.clk(clk), .rst(rst), .bus(if3));

    logic [3:0] pk_req;
    logic [1:0] pk_last;
    logic       pk_valid;
    logic [1:0] pk_idx;
    logic [3:0] pk_onehot;

    am2912_rr_pick #(.NREQ(4)) u_pick (
        .req    (pk_req),
        .last   (pk_last),
        .valid  (pk_valid),
        .idx    (pk_idx),
        .onehot (pk_onehot)
    );

    typedef struct {
        logic [3:0] req;
        logic [1:0] last;
        logic       valid;
        logic [1:0] idx;
        logic [3:0] oh;
    } pvec_t;

    // Reference model: who holds the bus, how long since grant, recovery left.
    typedef struct {
        int own;
        int age;
        int rec;
        int last;
    } mdl_t;

    int m_order[16];
    int m_strbs[16];
    int m_gaps[16];
    int m_n;
    bit m_twolow;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic mdl_t mreset();
        mdl_t n;
        n.own  = -1;
        n.age  = 0;
        n.rec  = 0;
        n.last = 3;
        return n;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic [3:0] rq, input logic r,
                                   input int S, input int R, input int H);
        mdl_t n;
        int   shown;
        int   k;
        n = m;
        shown = 0;
        if (r) begin
            n = mreset();
        end else if (m.own >= 0) begin
            shown = (m.age >= S) ? m.age - S + 1 : 0;
            if (!rq[2'(m.own)] || (H != 0 && shown >= H)) begin
                n.own = -1;
                n.rec = R;
            end else begin
                n.age = m.age + 1;
            end
        end else if (m.rec > 0) begin
            n.rec = m.rec - 1;
        end else begin
            for (int i = 1; i <= 4; i++) begin
                k = (m.last + i) % 4;
                if (n.own < 0 && rq[2'(k)]) begin
                    n.own  = k;
                    n.last = k;
                    n.age  = 0;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [11:0] mexp(input mdl_t m, input int S);
        logic [3:0] g;
        logic [1:0] o;
        g = (m.own >= 0) ? 4'(1 << m.own) : 4'b0000;
        o = (m.own >= 0) ? 2'(m.own) : 2'd0;
        return {g, ~g, (m.own >= 0 && m.age >= S), o, (m.own >= 0 || m.rec > 0)};
    endfunction

    task automatic mon1(input int ncyc);
        logic prev_on;
        int   gapc;
        prev_on = 1'b0;
        gapc    = 0;
        m_n     = 0;
        m_twolow = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_order[i] = -1;
            m_strbs[i] = 0;
            m_gaps[i]  = 0;
        end
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if ($countones(~if1.e_) > 1) m_twolow = 1'b1;
            if ((|if1.gnt) && !prev_on) begin
                if (m_n < 16) begin
                    m_order[m_n] = int'(if1.owner);
                    m_gaps[m_n]  = gapc;
                end
                m_n++;
            end
            if (!(|if1.gnt)) gapc++;
            else gapc = 0;
            if (if1.strb && m_n > 0 && m_n <= 16) m_strbs[m_n-1]++;
            prev_on = |if1.gnt;
        end
    endtask

    pvec_t pv[12];
    int    exp_order[5];
    int    bad;
    mdl_t  md0, md1;
    logic [3:0] flip0, flip1;

    initial begin
        pv[0]  = '{4'b0000, 2'd0, 1'b0, 2'd0, 4'b0000};
        pv[1]  = '{4'b0001, 2'd3, 1'b1, 2'd0, 4'b0001};
        pv[2]  = '{4'b1111, 2'd3, 1'b1, 2'd0, 4'b0001};
        pv[3]  = '{4'b1111, 2'd0, 1'b1, 2'd1, 4'b0010};
        pv[4]  = '{4'b1111, 2'd2, 1'b1, 2'd3, 4'b1000};
        pv[5]  = '{4'b0100, 2'd2, 1'b1, 2'd2, 4'b0100};
        pv[6]  = '{4'b1001, 2'd0, 1'b1, 2'd3, 4'b1000};
        pv[7]  = '{4'b1001, 2'd3, 1'b1, 2'd0, 4'b0001};
        pv[8]  = '{4'b0110, 2'd3, 1'b1, 2'd1, 4'b0010};
        pv[9]  = '{4'b0110, 2'd1, 1'b1, 2'd2, 4'b0100};
        pv[10] = '{4'b0110, 2'd2, 1'b1, 2'd1, 4'b0010};
        pv[11] = '{4'b1000, 2'd1, 1'b1, 2'd3, 4'b1000};

        if0.req = '0; if1.req = '0; if2.req = '0; if3.req = '0;
        pk_req = '0; pk_last = '0;

        for (int i = 0; i < 12; i++) begin
            pk_req  = pv[i].req;
            pk_last = pv[i].last;
            #1;
            chk($sformatf("pick[%0d]", i), 32'({pk_valid, pk_idx, pk_onehot}),
                32'({pv[i].valid, pv[i].idx, pv[i].oh}));
        end

        // Single requester, release on req drop.
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_gnt", 32'(if0.gnt), 32'h0);
        chk("rst_e", 32'(if0.e_), 32'hF);
        chk("rst_strb", 32'(if0.strb), 32'h0);
        chk("rst_owner", 32'(if0.owner), 32'h0);
        chk("rst_busy", 32'(if0.busy), 32'h0);
        if0.req = 4'b0001;
        tick();
        chk("t1_gnt", 32'(if0.gnt), 32'h1);
        chk("t1_e", 32'(if0.e_), 32'hE);
        chk("t1_strb0", 32'(if0.strb), 32'h0);
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (if0.strb !== 1'b1) bad++;
        end
        chk("t1_strb_run", 32'(bad), 32'h0);
        if0.req = 4'b0000;
        tick();
        chk("t1_rel_e", 32'(if0.e_), 32'hF);
        chk("t1_rel_strb", 32'(if0.strb), 32'h0);
        chk("t1_rel_busy", 32'(if0.busy), 32'h1);
        tick();
        chk("t1_idle_busy", 32'(if0.busy), 32'h0);

        // All request, MAX_HOLD=4: rotation with fixed tenure and gap.
        rst = 1'b1; if1.req = 4'b1111; tick(); rst = 1'b0;
        mon1(40);
        exp_order = '{0, 1, 2, 3, 0};
        chk("rr_count", 32'(m_n >= 5), 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_order[%0d]", i), 32'(m_order[i]), 32'(exp_order[i]));
            chk($sformatf("rr_strbs[%0d]", i), 32'(m_strbs[i]), 32'd4);
            if (i > 0) chk($sformatf("rr_gap[%0d]", i), 32'(m_gaps[i]), 32'd2);
        end
        chk("rr_twolow", 32'(m_twolow), 32'h0);

        // Lone requester is preempted and regranted.
        rst = 1'b1; if1.req = 4'b0100; tick(); rst = 1'b0;
        mon1(30);
        chk("solo_count", 32'(m_n >= 4), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("solo_order[%0d]", i), 32'(m_order[i]), 32'd2);
            chk($sformatf("solo_strbs[%0d]", i), 32'(m_strbs[i]), 32'd4);
            if (i > 0) chk($sformatf("solo_gap[%0d]", i), 32'(m_gaps[i]), 32'd2);
        end
        if1.req = 4'b0000;

        // Abort during SETTLE (SETTLE_CYC=3), then another requester goes first.
        rst = 1'b1; tick(); rst = 1'b0;
        if2.req = 4'b0010;
        tick();
        chk("ab_gnt", 32'(if2.gnt), 32'h2);
        if2.req = 4'b1000;
        tick();
        chk("ab_rel", 32'({if2.gnt, if2.e_, if2.strb, if2.busy}), 32'({4'h0, 4'hF, 1'b0, 1'b1}));
        if2.req = 4'b1010;
        tick();
        chk("ab_idle", 32'({if2.strb, if2.busy}), 32'h0);
        tick();
        chk("ab_next_gnt", 32'(if2.gnt), 32'h8);
        chk("ab_next_owner", 32'(if2.owner), 32'h3);
        if2.req = 4'b0000;

        // Reset in the middle of requester 3's tenure.
        rst = 1'b1; tick(); rst = 1'b0;
        if0.req = 4'b1000;
        tick(); tick(); tick();
        chk("mr_own", 32'({if0.owner, if0.strb}), 32'({2'd3, 1'b1}));
        rst = 1'b1; if0.req = 4'b1111;
        tick();
        chk("mr_rst", 32'({if0.gnt, if0.e_, if0.strb, if0.owner, if0.busy}), 32'({4'h0, 4'hF, 1'b0, 2'd0, 1'b0}));
        rst = 1'b0;
        tick();
        chk("mr_first", 32'(if0.gnt), 32'h1);
        if0.req = 4'b0000;

        // Unlimited tenure holds off other requesters.
        rst = 1'b1; tick(); rst = 1'b0;
        if3.req = 4'b0001;
        tick();
        if3.req = 4'b0111;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!(if3.strb === 1'b1 && if3.gnt === 4'b0001)) bad++;
        end
        chk("nh_hold", 32'(bad), 32'h0);
        if3.req = 4'b0110;
        tick();
        chk("nh_rel", 32'({if3.gnt, if3.strb}), 32'h0);
        tick();
        chk("nh_idle", 32'(if3.busy), 32'h0);
        tick();
        chk("nh_next", 32'(if3.gnt), 32'h2);
        if3.req = 4'b0000;

        // Randomized traffic against the model on two hold limits.
        rst = 1'b1; tick(); rst = 1'b0;
        md0 = mreset();
        md1 = mreset();
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 4; b++) begin
                flip0[b] = ($urandom_range(0, 5) == 0);
                flip1[b] = ($urandom_range(0, 5) == 0);
            end
            if0.req = if0.req ^ flip0;
            if1.req = if1.req ^ flip1;
            rst = ($urandom_range(0, 99) == 0);
            tick();
            md0 = mstep(md0, if0.req, rst, 1, 1, 16);
            md1 = mstep(md1, if1.req, rst, 1, 1, 4);
            chk("rnd_h16", 32'({if0.gnt, if0.e_, if0.strb, if0.owner, if0.busy}), 32'(mexp(md0, 1)));
            chk("rnd_h4", 32'({if1.gnt, if1.e_, if1.strb, if1.owner, if1.busy}), 32'(mexp(md1, 1)));
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/am2912_bus_arbiter.md
Name: am2912_bus_arbiter

Overview:
- Sequencer/arbiter for an open-collector bus built from am2912 quad transceivers.
- Shares one wired-AND bus segment between NREQ requesters, each owning one transceiver bank.
- Drives each bank's active-low enable (e_), inserts settle and recovery gaps for pull-up rise time, and emits a sample strobe so receivers read the z outputs only when the bus is stable.
- Round-robin fairness with an optional maximum tenure.

Parameters:
- NREQ, 4, number of requesters / transceiver banks (2..16).
- SETTLE_CYC, 1, cycles after enable before the bus is declared valid (1..15).
- RECOVER_CYC, 1, idle cycles after release before the next grant (1..15).
- MAX_HOLD, 16, maximum OWN cycles per tenure; 0 = unlimited (0..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NREQ  per-requester bus request, level, held while the bus is wanted.
- gnt  output  NREQ  one-hot grant, registered.
- e_  output  NREQ  active-low transceiver enables, one per am2912 bank; at most one low.
- strb  output  1  bus valid: receivers sample z this cycle.
- owner  output  $clog2(NREQ)  index of the current grantee; 0 when idle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: synchronous, active-high, on clk rising edge; sync reset is the only reset.
  - Outputs on the edge where rst is sampled high: state=IDLE, gnt=0, e_=all 1, strb=0, owner=0, busy=0, counters=0, last=NREQ-1 (so req[0] wins first).
  - Applies mid-tenure too: the bus is released on that edge with no RECOVER gap.
- All outputs are registered. Invariant: e_[k]==~gnt[k].
- States: IDLE, SETTLE, OWN, RECOVER.
- IDLE:
  - If |req, pick k = first set bit searching last+1, last+2, … modulo NREQ.
  - Next edge: gnt[k]=1, e_[k]=0, owner=k, last=k, cnt=0, go to SETTLE.
  - Latency from req rising to gnt is 1 cycle.
- SETTLE:
  - Count SETTLE_CYC cycles.
  - On the last one, go to OWN with strb=1 on the same edge.
  - If req[owner] drops during SETTLE, go to RECOVER (abort; strb never asserted).
- OWN:
  - strb=1 every cycle; hold counter increments.
  - Exit to RECOVER when req[owner]==0 (sampled), or when MAX_HOLD!=0 and the hold count reaches MAX_HOLD.
  - Preemption: strb is high for exactly MAX_HOLD cycles.
  - On exit edge: gnt=0, e_=all 1, strb=0.
- RECOVER:
  - All e_ high for RECOVER_CYC cycles, then IDLE.
  - Arbitration happens in IDLE, so the minimum gap between e_ release and the next e_ low is RECOVER_CYC+1 cycles.
- Fairness:
  - A preempted requester still holding req is regranted only if no other req is set.
  - Requests arriving mid-tenure are not latched; they are evaluated at IDLE.
- Simultaneous events:
  - req drop and MAX_HOLD expiry on the same cycle give one release; there is no double count.
- Counter widths: 4 bits for settle/recover, 8 bits for hold. Parameters outside range are a compile-time $error.

Decomposition:
- Shared defines include: state encoding localparams (IDLE=0, SETTLE=1, OWN=2, RECOVER=3) and am2912 enable polarity constants, reused by later bus controllers.
- One sub-module: am2912_rr_pick.
  - Combinational round-robin picker.
  - Inputs: req[NREQ], last[$clog2(NREQ)].
  - Outputs: valid, idx, onehot.
  - Unit-tested standalone.

Test Plan:
- Reset then req=4'b0001 held 10 cycles (SETTLE_CYC=1, RECOVER_CYC=1, MAX_HOLD=16):
  - gnt=0001 and e_=1110 one cycle after req.
  - strb rises 1 cycle later and stays high until req drops.
  - e_=1111 on the edge after req falls; busy low 2 cycles later.
- req=4'b1111 held constantly, MAX_HOLD=4:
  - Grant order 0,1,2,3,0.
  - Each tenure has exactly 4 strb cycles.
  - e_ never has two bits low; at least 2 all-ones cycles between tenures.
- req=4'b0100 only, held, MAX_HOLD=4:
  - Requester 2 preempted after 4 strb cycles, then regranted after the RECOVER+IDLE gap; repeats.
- req[1] asserted, dropped during SETTLE with SETTLE_CYC=3:
  - strb never asserts; RECOVER entered; next grant goes to any other pending req before req[1].
- rst pulsed high for 1 cycle during OWN of requester 3:
  - Next edge: e_=1111, gnt=0, strb=0, owner=0.
  - With req=1111 afterwards, first grant is requester 0.
- MAX_HOLD=0, req[0] held 300 cycles:
  - Continuous strb for the whole tenure, no preemption.
  - Other requests wait until req[0] falls.
